// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter: the buffered result
// entry and the round-robin source selector.
package wb_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_MEM = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries. Ready is registered (not full) and
// every slot is exposed with a valid bit so the parent can build busy_mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   empty,
    output logic                   ready,
    output wb_entry_t [DEPTH-1:0]  entries,
    output logic [DEPTH-1:0]       entry_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  ready_q, ready_d;
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;

    // Next-state for storage, pointers, occupancy and the registered ready.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != (PW+1)'(DEPTH));
    end

    // State registers; ready is forced low for as long as reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // A slot is live when its distance from the read pointer is below occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign empty   = (count_q == (PW+1)'(0));
    assign ready   = ready_q;
    assign entries = mem_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Drives the single register-file write port from the ALU and load-return
// paths, buffering each in a small FIFO and arbitrating round-robin on conflict.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREG  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [REG_W-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    output logic             write,
    output logic [REG_W-1:0] reg_addr,
    output logic [XLEN-1:0]  reg_data,
    output logic [NREG-1:0]  busy_mask
);

    logic                  alu_push, mem_push;
    logic                  grant_alu, grant_mem;
    logic                  alu_empty, mem_empty;
    wb_entry_t             alu_head, mem_head;
    wb_entry_t [DEPTH-1:0] alu_entries, mem_entries;
    logic [DEPTH-1:0]      alu_vld, mem_vld;

    wb_src_e               ptr_q, ptr_d;
    logic                  write_q, write_d;
    logic [REG_W-1:0]      reg_addr_q, reg_addr_d;
    logic [XLEN-1:0]       reg_data_q, reg_data_d;
    logic [NREG-1:0]       busy_d;

    // Writes to x0 complete the handshake but are dropped here.
    assign alu_push = alu_valid && alu_ready && (alu_rd != REG_W'(0));
    assign mem_push = mem_valid && mem_ready && (mem_rd != REG_W'(0));

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (alu_push),
        .push_entry  ('{rd: alu_rd, data: alu_data}),
        .pop         (grant_alu),
        .head        (alu_head),
        .empty       (alu_empty),
        .ready       (alu_ready),
        .entries     (alu_entries),
        .entry_valid (alu_vld)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (mem_push),
        .push_entry  ('{rd: mem_rd, data: mem_data}),
        .pop         (grant_mem),
        .head        (mem_head),
        .empty       (mem_empty),
        .ready       (mem_ready),
        .entries     (mem_entries),
        .entry_valid (mem_vld)
    );

    // Grant selection; the pointer only advances when both heads compete.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        ptr_d     = ptr_q;
        case ({!alu_empty, !mem_empty})
            2'b10: grant_alu = 1'b1;
            2'b01: grant_mem = 1'b1;
            2'b11: begin
                if (ptr_q == WB_SRC_MEM) begin
                    grant_mem = 1'b1;
                    ptr_d     = WB_SRC_ALU;
                end else begin
                    grant_alu = 1'b1;
                    ptr_d     = WB_SRC_MEM;
                end
            end
            default: ptr_d = ptr_q;
        endcase
    end

    // Output port next-state; address and data hold when nothing is granted.
    always_comb begin
        write_d    = grant_alu || grant_mem;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        if (grant_mem) begin
            reg_addr_d = mem_head.rd;
            reg_data_d = mem_head.data;
        end else if (grant_alu) begin
            reg_addr_d = alu_head.rd;
            reg_data_d = alu_head.data;
        end else begin
            reg_addr_d = reg_addr_q;
            reg_data_d = reg_data_q;
        end
    end

    // Output port and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q    <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            ptr_q      <= WB_SRC_MEM;
        end else begin
            write_q    <= write_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            ptr_q      <= ptr_d;
        end
    end

    // Pending-write mask over both FIFOs plus the write currently on the port.
    always_comb begin
        busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[alu_entries[i].rd] = busy_d[alu_entries[i].rd] | alu_vld[i];
            busy_d[mem_entries[i].rd] = busy_d[mem_entries[i].rd] | mem_vld[i];
        end
        busy_d[reg_addr_q] = busy_d[reg_addr_q] | write_q;
    end

    assign write     = write_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;
    assign busy_mask = busy_d;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: one task per scenario, inline checks,
// outputs sampled 1ns after each rising edge.
module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        write;
    logic [4:0]  reg_addr;
    logic [63:0] reg_data;
    logic [31:0] busy_mask;

    int tests;
    int fails;

    writeback_arbiter #(.XLEN(64), .NREG(32), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .write     (write),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .busy_mask (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = 5'd0; alu_data = 64'd0; mem_rd = 5'd0; mem_data = 64'd0;
        reset = 1'b1;
        tick();
        tick();
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write: got %0h expected 0", write); end
        tests++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL reset_busy: got %0h expected 0", busy_mask); end
        tests++; if ({alu_ready, mem_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready_low: got %0b expected 00", {alu_ready, mem_ready}); end
        reset = 1'b0;
        tick();
        tests++; if ({alu_ready, mem_ready} !== 2'b11) begin fails++; $display("FAIL reset_ready_high: got %0b expected 11", {alu_ready, mem_ready}); end
        tests++; if ({write, reg_addr, reg_data} !== 70'd0) begin fails++; $display("FAIL reset_port: got %0h expected 0", {write, reg_addr, reg_data}); end
    endtask

    task automatic test_single();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL single_early_write: got %0h expected 0", write); end
        tests++; if (busy_mask !== 32'h20) begin fails++; $display("FAIL single_busy_fifo: got %0h expected 20", busy_mask); end
        tick();
        tests++; if ({write, reg_addr, reg_data} !== {1'b1, 5'd5, 64'hDEAD_BEEF}) begin
            fails++; $display("FAIL single_write: got %0h expected %0h", {write, reg_addr, reg_data}, {1'b1, 5'd5, 64'hDEAD_BEEF});
        end
        tests++; if (busy_mask !== 32'h20) begin fails++; $display("FAIL single_busy_out: got %0h expected 20", busy_mask); end
        tick();
        tests++; if ({write, busy_mask} !== 33'd0) begin fails++; $display("FAIL single_done: got %0h expected 0", {write, busy_mask}); end
        tests++; if ({reg_addr, reg_data} !== {5'd5, 64'hDEAD_BEEF}) begin fails++; $display("FAIL single_hold: got %0h expected %0h", {reg_addr, reg_data}, {5'd5, 64'hDEAD_BEEF}); end
    endtask

    task automatic test_contention();
        logic [4:0] first_rd [0:2];
        logic [4:0] second_rd [0:2];
        first_rd[0] = 5'd4; second_rd[0] = 5'd3;
        first_rd[1] = 5'd3; second_rd[1] = 5'd4;
        first_rd[2] = 5'd4; second_rd[2] = 5'd3;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'd1;
            mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'd2;
            tick();
            alu_valid = 1'b0; mem_valid = 1'b0;
            tests++; if (busy_mask !== 32'h18) begin fails++; $display("FAIL contend_busy round %0d: got %0h expected 18", r, busy_mask); end
            tick();
            tests++; if ({write, reg_addr} !== {1'b1, first_rd[r]}) begin fails++; $display("FAIL contend_first round %0d: got %0h expected %0h", r, {write, reg_addr}, {1'b1, first_rd[r]}); end
            tests++; if (reg_data !== ((first_rd[r] == 5'd4) ? 64'd2 : 64'd1)) begin fails++; $display("FAIL contend_first_data round %0d: got %0h", r, reg_data); end
            tick();
            tests++; if ({write, reg_addr} !== {1'b1, second_rd[r]}) begin fails++; $display("FAIL contend_second round %0d: got %0h expected %0h", r, {write, reg_addr}, {1'b1, second_rd[r]}); end
            tick();
            tests++; if (write !== 1'b0) begin fails++; $display("FAIL contend_idle round %0d: got %0h expected 0", r, write); end
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp_d [0:5];
        logic [4:0]  exp_a [0:5];
        logic [5:0]  exp_ar;
        logic        hs_a, hs_m;
        exp_d[0] = 64'd105; exp_d[1] = 64'd200; exp_d[2] = 64'd106;
        exp_d[3] = 64'd201; exp_d[4] = 64'd107; exp_d[5] = 64'd202;
        exp_a[0] = 5'd7; exp_a[1] = 5'd9; exp_a[2] = 5'd7;
        exp_a[3] = 5'd9; exp_a[4] = 5'd7; exp_a[5] = 5'd9;
        exp_ar = 6'b010101;
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'd100;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL stream_ready step %0d: got %0h expected 1", i, alu_ready); end
            if (i > 0) begin
                tests++; if ({write, reg_data} !== {1'b1, 64'd100 + 64'(i - 1)}) begin
                    fails++; $display("FAIL stream_write step %0d: got %0h expected %0h", i, {write, reg_data}, {1'b1, 64'd100 + 64'(i - 1)});
                end
            end
            alu_data = alu_data + 64'd1;
        end
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'd200;
        for (int j = 0; j < 6; j++) begin
            hs_a = alu_valid && alu_ready;
            hs_m = mem_valid && mem_ready;
            tick();
            if (hs_a) alu_data = alu_data + 64'd1;
            if (hs_m) mem_data = mem_data + 64'd1;
            tests++; if ({write, reg_addr, reg_data} !== {1'b1, exp_a[j], exp_d[j]}) begin
                fails++; $display("FAIL alt_write step %0d: got %0h expected %0h", j, {write, reg_addr, reg_data}, {1'b1, exp_a[j], exp_d[j]});
            end
            tests++; if (alu_ready !== exp_ar[j]) begin fails++; $display("FAIL alt_alu_ready step %0d: got %0h expected %0h", j, alu_ready, exp_ar[j]); end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_rd0();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h1234;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL rd0_handshake: got %0h expected 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++; if ({write, busy_mask} !== 33'd0) begin fails++; $display("FAIL rd0_quiet step %0d: got %0h expected 0", k, {write, busy_mask}); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hA;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'hC;
        tick();
        alu_rd = 5'd11; alu_data = 64'hB;
        mem_rd = 5'd13; mem_data = 64'hD;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        tests++; if (busy_mask !== 32'h3C00) begin fails++; $display("FAIL mid_busy_before: got %0h expected 3c00", busy_mask); end
        reset = 1'b1;
        tick();
        tests++; if ({write, busy_mask} !== 33'd0) begin fails++; $display("FAIL mid_cleared: got %0h expected 0", {write, busy_mask}); end
        tests++; if ({alu_ready, mem_ready} !== 2'b00) begin fails++; $display("FAIL mid_ready_low: got %0b expected 00", {alu_ready, mem_ready}); end
        reset = 1'b0;
        tick();
        tests++; if ({alu_ready, mem_ready} !== 2'b11) begin fails++; $display("FAIL mid_ready_high: got %0b expected 11", {alu_ready, mem_ready}); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (write !== 1'b0) begin fails++; $display("FAIL mid_stale step %0d: got %0h expected 0", k, write); end
            tick();
        end
    endtask

    task automatic test_full_mem();
        int          na, nm;
        logic        hs_a, hs_m;
        na = 0; nm = 0;
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'd400;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 64'd300;
        for (int e = 1; e <= 16; e++) begin
            hs_a = alu_valid && alu_ready;
            hs_m = mem_valid && mem_ready;
            tick();
            if (hs_a) alu_data = alu_data + 64'd1;
            if (hs_m) mem_data = mem_data + 64'd1;
            if (e == 3) begin
                tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL full_mem_ready: got %0h expected 0", mem_ready); end
            end
            if (e == 4) begin
                tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL full_mem_reopen: got %0h expected 1", mem_ready); end
            end
            if (e == 6) begin
                alu_valid = 1'b0; mem_valid = 1'b0;
            end
            if (write) begin
                tests++;
                if (reg_addr == 5'd20) begin
                    if (reg_data !== 64'd300 + 64'(nm)) begin fails++; $display("FAIL full_mem_order: got %0h expected %0h", reg_data, 64'd300 + 64'(nm)); end
                    nm++;
                end else if (reg_addr == 5'd21) begin
                    if (reg_data !== 64'd400 + 64'(na)) begin fails++; $display("FAIL full_alu_order: got %0h expected %0h", reg_data, 64'd400 + 64'(na)); end
                    na++;
                end else begin
                    fails++; $display("FAIL full_addr: got %0h expected 14 or 15", reg_addr);
                end
            end
        end
        tests++; if (nm !== 4) begin fails++; $display("FAIL full_mem_count: got %0d expected 4", nm); end
        tests++; if (na !== 4) begin fails++; $display("FAIL full_alu_count: got %0d expected 4", na); end
        tests++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL full_drained: got %0h expected 0", busy_mask); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_contention();
        test_stream();
        test_rd0();
        test_reset_mid();
        test_full_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
